// File: rtl/rotation_pkg.sv
// Shared constants and types for the rotation front end and the dial datapath.
package rotation_pkg;

  localparam int VALUE_WIDTH_DEFAULT = 16;
  localparam int DIAL_START          = 50;
  localparam int DIAL_MODULUS        = 100;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIGITS = 3'd1,
    ST_EMIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } parser_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/rotation_parser_decimal_accumulator.sv
// Saturating decimal accumulator: value <= value*10 + digit, clamped to all-ones.
module decimal_accumulator #(
  parameter int VALUE_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_clear,
  input  logic                   i_digit_valid,
  input  logic [3:0]             i_digit,
  output logic [VALUE_WIDTH-1:0] o_value,
  output logic [VALUE_WIDTH-1:0] o_next
);

  logic [VALUE_WIDTH-1:0] r_acc;
  logic [VALUE_WIDTH+3:0] w_wide;
  logic [VALUE_WIDTH+3:0] w_x10;
  logic [VALUE_WIDTH+3:0] w_sum;
  logic [VALUE_WIDTH-1:0] w_step;

  // Four spare bits hold acc*10+9 exactly, so any nonzero top bit means overflow.
  assign w_wide = {4'd0, r_acc};
  assign w_x10  = (w_wide << 3) + (w_wide << 1);
  assign w_sum  = w_x10 + {{VALUE_WIDTH{1'b0}}, i_digit};
  assign w_step = (|w_sum[VALUE_WIDTH+3:VALUE_WIDTH]) ? {VALUE_WIDTH{1'b1}}
                                                      : w_sum[VALUE_WIDTH-1:0];

  always_comb begin
    o_next = r_acc;
    if (i_clear)
      o_next = '0;
    else if (i_digit_valid)
      o_next = w_step;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_acc <= '0;
    else
      r_acc <= o_next;
  end

  assign o_value = r_acc;

endmodule

// File: rtl/rotation_parser.sv
// Turns an ASCII stream of "R<n>\n" / "L<n>\n" lines into rotation commands.
module rotation_parser
  import rotation_pkg::*;
#(
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [VALUE_WIDTH-1:0] cmd_value,
  output logic                   cmd_positive,
  output logic                   cmd_last,
  output logic [15:0]            line_count,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             dbg_state
);

  // Both interfaces: a transfer happens on a rising edge where valid & ready;
  // a producer holds valid and its payload stable until that transfer.

  parser_state_t          r_state;
  parser_state_t          w_state_next;
  logic                   r_ready_en;
  logic                   r_dir;
  logic                   r_digit_seen;
  logic [VALUE_WIDTH-1:0] r_cmd_value;
  logic                   r_cmd_positive;
  logic                   r_cmd_last;
  logic [15:0]            r_line_count;

  logic                   w_fire;
  logic                   w_acc_clear;
  logic                   w_acc_dv;
  logic                   w_start_cmd;
  logic                   w_set_seen;
  logic                   w_enter_emit;
  logic                   w_emit_last;
  logic                   w_count_inc;
  logic [VALUE_WIDTH-1:0] w_acc_value;
  logic [VALUE_WIDTH-1:0] w_acc_next;

  decimal_accumulator #(.VALUE_WIDTH(VALUE_WIDTH)) u_acc (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_clear       (w_acc_clear),
    .i_digit_valid (w_acc_dv),
    .i_digit       (in_data[3:0]),
    .o_value       (w_acc_value),
    .o_next        (w_acc_next)
  );

  assign in_ready = r_ready_en && (r_state == ST_IDLE || r_state == ST_DIGITS);
  assign w_fire   = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    w_acc_clear  = 1'b0;
    w_acc_dv     = 1'b0;
    w_start_cmd  = 1'b0;
    w_set_seen   = 1'b0;
    w_enter_emit = 1'b0;
    w_emit_last  = 1'b0;
    w_count_inc  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_fire) begin
        if (in_data == CH_R || in_data == CH_L) begin
          w_start_cmd  = 1'b1;
          w_acc_clear  = 1'b1;
          w_state_next = in_last ? ST_ERROR : ST_DIGITS;
        end else if (in_data == CH_LF || in_data == CH_CR) begin
          w_state_next = in_last ? ST_DONE : ST_IDLE;
        end else begin
          w_state_next = ST_ERROR;
        end
      end
      ST_DIGITS: if (w_fire) begin
        if (is_digit(in_data)) begin
          w_acc_dv   = 1'b1;
          w_set_seen = 1'b1;
          if (in_last) begin
            w_enter_emit = 1'b1;
            w_emit_last  = 1'b1;
            w_state_next = ST_EMIT;
          end
        // A carriage return carrying in_last terminates the line like '\n'.
        end else if (in_data == CH_LF || (in_data == CH_CR && in_last)) begin
          if (r_digit_seen) begin
            w_enter_emit = 1'b1;
            w_emit_last  = in_last;
            w_state_next = ST_EMIT;
          end else begin
            w_state_next = ST_ERROR;
          end
        end else if (in_data != CH_CR) begin
          w_state_next = ST_ERROR;
        end
      end
      ST_EMIT: if (cmd_ready) begin
        w_count_inc  = 1'b1;
        w_state_next = r_cmd_last ? ST_DONE : ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_ready_en     <= 1'b0;
      r_dir          <= 1'b0;
      r_digit_seen   <= 1'b0;
      r_cmd_value    <= '0;
      r_cmd_positive <= 1'b0;
      r_cmd_last     <= 1'b0;
      r_line_count   <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_ready_en <= 1'b1;
      if (w_start_cmd) begin
        r_dir        <= (in_data == CH_R);
        r_digit_seen <= 1'b0;
      end else if (w_set_seen) begin
        r_digit_seen <= 1'b1;
      end
      // Capture the post-update accumulator so a final digit with in_last counts.
      if (w_enter_emit) begin
        r_cmd_value    <= w_acc_next;
        r_cmd_positive <= r_dir;
        r_cmd_last     <= w_emit_last;
      end
      if (w_count_inc)
        r_line_count <= r_line_count + 16'd1;
    end
  end

  assign cmd_valid    = (r_state == ST_EMIT);
  assign cmd_value    = r_cmd_value;
  assign cmd_positive = r_cmd_positive;
  assign cmd_last     = r_cmd_last;
  assign line_count   = r_line_count;
  assign done         = (r_state == ST_DONE);
  assign error        = (r_state == ST_ERROR);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_rotation_parser.sv
// Directed bench for rotation_parser: a vector table of single lines plus corner sequences.
module tb_rotation_parser;
  import rotation_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_value;
  logic        cmd_positive;
  logic        cmd_last;
  logic [15:0] line_count;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  int n_vec;
  int n_miss;
  int exp_count;

  typedef struct {
    string       line;
    logic [15:0] value;
    logic        positive;
  } vec_t;

  vec_t tbl[9];

  rotation_parser #(.VALUE_WIDTH(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_value    (cmd_value),
    .cmd_positive (cmd_positive),
    .cmd_last     (cmd_last),
    .line_count   (line_count),
    .done         (done),
    .error        (error),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out, required event never came", name);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    cmd_ready = 1'b1;
    exp_count = 0;
    repeat (2) @(negedge clock);
    check("reset in_ready", in_ready, 0);
    check("reset cmd_valid", cmd_valid, 0);
    check("reset line_count", line_count, 0);
    check("reset done/error", {done, error}, 0);
    reset_n = 1'b1;
    check("in_ready low at release", in_ready, 0);
    @(negedge clock);
    check("in_ready after release", in_ready, 1);
  endtask

  // driver: present a byte at a falling edge, hold until accepted
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) fail_timeout("in_ready wait");
    else @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_line(input string s, input logic last_final);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_final && (i == s.len() - 1));
  endtask

  task automatic wait_cmd(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!cmd_valid && lat < 16);
    if (!cmd_valid) fail_timeout("cmd_valid wait");
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    @(posedge clock);
    #1;
    exp_count++;
  endtask

  initial begin
    int lat;
    n_vec     = 0;
    n_miss    = 0;
    exp_count = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    cmd_ready = 1'b1;

    tbl[0] = '{"R48\n",      16'd48,    1'b1};
    tbl[1] = '{"L68\n",      16'd68,    1'b0};
    tbl[2] = '{"R0\n",       16'd0,     1'b1};
    tbl[3] = '{"L65535\n",   16'd65535, 1'b0};
    tbl[4] = '{"R65540\n",   16'd65535, 1'b1};
    tbl[5] = '{"\n\nL0\r\n", 16'd0,     1'b0};
    tbl[6] = '{"R99999\n",   16'd65535, 1'b1};
    tbl[7] = '{"L7\r\n",     16'd7,     1'b0};
    tbl[8] = '{"\r\nR007\n", 16'd7,     1'b1};

    do_reset();

    // single-line vectors, downstream always ready
    for (int v = 0; v < 9; v++) begin
      send_line(tbl[v].line, 1'b0);
      wait_cmd(lat);
      check($sformatf("vec%0d latency", v), lat, 1);
      check($sformatf("vec%0d value", v), cmd_value, tbl[v].value);
      check($sformatf("vec%0d positive", v), cmd_positive, tbl[v].positive);
      check($sformatf("vec%0d last", v), cmd_last, 0);
      handshake();
      check($sformatf("vec%0d line_count", v), line_count, exp_count);
      check($sformatf("vec%0d cmd_valid drop", v), cmd_valid, 0);
      check($sformatf("vec%0d error", v), error, 0);
    end

    // back-pressure: two lines, 3 stall cycles each, in_last on final newline
    do_reset();
    cmd_ready = 1'b0;
    send_line("L68\n", 1'b0);
    wait_cmd(lat);
    check("stall1 latency", lat, 1);
    repeat (3) begin
      check("stall1 value", cmd_value, 68);
      check("stall1 positive", cmd_positive, 0);
      check("stall1 in_ready", in_ready, 0);
      check("stall1 cmd_valid", cmd_valid, 1);
      @(negedge clock);
    end
    handshake();
    cmd_ready = 1'b0;
    check("stall1 line_count", line_count, 1);
    send_line("L30\n", 1'b1);
    wait_cmd(lat);
    repeat (3) begin
      check("stall2 value", cmd_value, 30);
      check("stall2 last", cmd_last, 1);
      check("stall2 in_ready", in_ready, 0);
      @(negedge clock);
    end
    handshake();
    @(negedge clock);
    check("stall2 done", done, 1);
    check("stall2 line_count", line_count, 2);
    check("stall2 cmd_valid", cmd_valid, 0);
    check("stall2 in_ready", in_ready, 0);

    // malformed first byte
    do_reset();
    send_byte(8'h58, 1'b0);
    @(negedge clock);
    check("X error", error, 1);
    check("X dbg_state", dbg_state, ST_ERROR);
    in_valid = 1'b1;
    in_data  = 8'h35;
    repeat (3) begin
      @(negedge clock);
      check("X in_ready", in_ready, 0);
      check("X cmd_valid", cmd_valid, 0);
    end
    in_valid = 1'b0;

    // direction with no digits
    do_reset();
    send_line("L\n", 1'b0);
    @(negedge clock);
    check("L-nl error", error, 1);
    check("L-nl cmd_valid", cmd_valid, 0);

    // in_last on a digit, no newline
    do_reset();
    send_line("R12", 1'b1);
    wait_cmd(lat);
    check("R12 latency", lat, 1);
    check("R12 value", cmd_value, 12);
    check("R12 last", cmd_last, 1);
    handshake();
    @(negedge clock);
    check("R12 done", done, 1);
    check("R12 line_count", line_count, 1);

    // asynchronous reset in the middle of a line
    do_reset();
    send_line("R5\n", 1'b0);
    wait_cmd(lat);
    handshake();
    send_line("R9", 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst in_ready", in_ready, 0);
    check("midrst cmd_value", cmd_value, 0);
    check("midrst cmd_positive", cmd_positive, 0);
    check("midrst line_count", line_count, 0);
    check("midrst cmd_valid", cmd_valid, 0);
    check("midrst dbg_state", dbg_state, ST_IDLE);
    @(negedge clock);
    reset_n   = 1'b1;
    exp_count = 0;
    send_line("L3\n", 1'b0);
    wait_cmd(lat);
    check("post-reset value", cmd_value, 3);
    check("post-reset positive", cmd_positive, 0);
    handshake();
    check("post-reset line_count", line_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
